main_mem_arbiter: RTL and testbench



---
 rtl/main_mem_arb_pkg.sv | 18 +
 rtl/mem_arb_picker.sv | 30 +++
 rtl/main_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_main_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_arb_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
// ARB_ROUND_ROBIN_EN (optional) switches the picker to round-robin.
package main_mem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select between I and D requests.
// ARB_ROUND_ROBIN_EN: ties go to the side not granted last; else D wins.
module mem_arb_picker
  import main_mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic i_last_grant,
`endif
  output logic o_winner
);

  // pick the winner; only meaningful when at least one side requests
  always_comb begin
    o_winner = REQ_I;
    unique case (1'b1)
      (i_req_i & i_req_d): begin
`ifdef ARB_ROUND_ROBIN_EN
        o_winner = ~i_last_grant;
`else
        o_winner = REQ_D;
`endif
      end
      (i_req_d & ~i_req_i): o_winner = REQ_D;
      default:              o_winner = REQ_I;
    endcase
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares one word-wide data memory between the I-cache and D-cache.
// ARB_ROUND_ROBIN_EN selects round-robin ties instead of D priority.
module main_mem_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_writedata,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_t        r_state;
  logic              r_win;
  logic              r_wr;
  logic              r_ack_i;
  logic              r_ack_d;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_i;
  logic [DATA_W-1:0] r_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              r_last;
`endif

  logic w_req_i;
  logic w_req_d;
  logic w_win;

  // read and write together cancel out to no request
  assign w_req_i = i_read ^ i_write;
  assign w_req_d = d_read ^ d_write;

  assign i_busywait = w_req_i & ~r_ack_i & reset;
  assign d_busywait = w_req_d & ~r_ack_d & reset;

  assign i_readdata    = r_rdata_i;
  assign d_readdata    = r_rdata_d;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_addr;
  assign mem_writedata = r_wdata;

  mem_arb_picker u_picker (
    .i_req_i      (w_req_i),
    .i_req_d      (w_req_d),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_grant (r_last),
`endif
    .o_winner     (w_win)
  );

  // single-transaction FSM: grant, issue, wait on memory, ack
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_win       <= REQ_I;
      r_wr        <= 1'b0;
      r_ack_i     <= 1'b0;
      r_ack_d     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_i   <= '0;
      r_rdata_d   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last      <= REQ_I;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req_i | w_req_d) begin
            r_win   <= w_win;
            r_wr    <= (w_win == REQ_D) ? d_write : i_write;
            r_addr  <= (w_win == REQ_D) ? d_address : i_address;
            r_wdata <= (w_win == REQ_D) ? d_writedata
                                        : i_writedata;
`ifdef ARB_ROUND_ROBIN_EN
            r_last  <= w_win;
`endif
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_read  <= ~r_wr;
          r_mem_write <= r_wr;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (!mem_busywait) begin
            if (!r_wr) begin
              if (r_win == REQ_D) r_rdata_d <= mem_readdata;
              else                r_rdata_i <= mem_readdata;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ack_i     <= (r_win == REQ_I);
            r_ack_d     <= (r_win == REQ_D);
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_ack_i <= 1'b0;
          r_ack_d <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: 5-cycle data memory, timeline model, directed tests.
// Works with or without ARB_ROUND_ROBIN_EN defined.
module tb_main_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_read = 1'b0, i_write = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_writedata = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  main_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_address(i_address),
    .i_writedata(i_writedata), .i_readdata(i_readdata),
    .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_readdata(d_readdata),
    .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  function automatic logic [31:0] initval(int k);
    return (k == 10) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(k));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // data memory: busy for 5 edges after an op starts, write lands as busy drops
  logic [DW-1:0] mem [64];
  bit            minit = 0;
  int            mcnt = 0;
  wire           w_op = mem_read | mem_write;
  assign mem_busywait = w_op && (mcnt < 5);
  assign mem_readdata = mem[mem_address];

  always @(posedge clock) begin
    if (!minit) begin
      for (int k = 0; k < 64; k++) mem[k] <= initval(k);
      minit <= 1;
    end else if (w_op && mcnt == 5 && mem_write) begin
      mem[mem_address] <= mem_writedata;
    end
    mcnt <= w_op ? mcnt + 1 : 0;
  end

  // transaction timeline model: grant at edge t0, op on for ages 1..6,
  // completion at age 7 (ack cycle follows), free again at age 8
  int            e = 0;
  bit            mv = 0;
  bit            rinit = 0;
  bit            m_act = 0;
  bit            m_win = 0;
  bit            m_wr = 0;
  int            m_t0 = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] refm [64];
`ifdef ARB_ROUND_ROBIN_EN
  bit            m_last = 0;
`endif

  always @(posedge clock) begin : model
    int age;
    bit ri, rq, w;
    e <= e + 1;
    if (!rinit) begin
      for (int k = 0; k < 64; k++) refm[k] <= initval(k);
      rinit <= 1;
    end
    if (!reset) begin
      m_act    <= 0;
      m_addr   <= '0;
      m_wd     <= '0;
      m_rd[0]  <= '0;
      m_rd[1]  <= '0;
      mv       <= 1;
`ifdef ARB_ROUND_ROBIN_EN
      m_last   <= 0;
`endif
    end else if (m_act) begin
      age = e + 1 - m_t0;
      if (age == 7) begin
        if (m_wr) refm[m_addr] <= m_wd;
        else      m_rd[m_win] <= refm[m_addr];
      end
      if (age == 8) m_act <= 0;
    end else begin
      ri = i_read ^ i_write;
      rq = d_read ^ d_write;
      if (ri | rq) begin
        w = rq;
`ifdef ARB_ROUND_ROBIN_EN
        if (ri && rq) w = ~m_last;
        m_last <= w;
`endif
        m_act  <= 1;
        m_t0   <= e + 1;
        m_win  <= w;
        m_wr   <= w ? d_write : i_write;
        m_addr <= w ? d_address : i_address;
        m_wd   <= w ? d_writedata : i_writedata;
      end
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clock) begin : cmp
    int age;
    bit on, ak_i, ak_d, bw_i, bw_d;
    if (mv) begin
      age  = e - m_t0;
      on   = m_act && age >= 1 && age <= 6;
      ak_i = m_act && age == 7 && !m_win;
      ak_d = m_act && age == 7 && m_win;
      bw_i = (i_read ^ i_write) && !ak_i && reset;
      bw_d = (d_read ^ d_write) && !ak_d && reset;
      chk("mem_read", 32'(mem_read), 32'(on && !m_wr));
      chk("mem_write", 32'(mem_write), 32'(on && m_wr));
      chk("mem_address", 32'(mem_address), 32'(m_addr));
      chk("mem_writedata", mem_writedata, m_wd);
      chk("i_busywait", 32'(i_busywait), 32'(bw_i));
      chk("d_busywait", 32'(d_busywait), 32'(bw_d));
      chk("i_readdata", i_readdata, m_rd[0]);
      chk("d_readdata", d_readdata, m_rd[1]);
    end
  end

  task automatic wait_bw(input bit side, output int t);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((side ? d_busywait : i_busywait) && n < 60);
    n_cmp++;
    if (side ? d_busywait : i_busywait) begin
      n_bad++;
      $display("FAIL %s_timeout: busywait still 1 after %0d cycles, required 0",
               side ? "d" : "i", n);
    end
    t = e;
  endtask

  task automatic d_req(input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output int t);
    @(negedge clock);
    #1;
    d_read = !wr; d_write = wr; d_address = a; d_writedata = wd;
    wait_bw(1'b1, t);
    #1;
    d_read = 0; d_write = 0;
  endtask

  task automatic i_req(input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output int t);
    @(negedge clock);
    #1;
    i_read = !wr; i_write = wr; i_address = a; i_writedata = wd;
    wait_bw(1'b0, t);
    #1;
    i_read = 0; i_write = 0;
  endtask

  task automatic d_burst(output int t0, output int t1, output int t2);
    @(negedge clock);
    #1;
    d_read = 1; d_write = 0; d_address = 6'h11;
    wait_bw(1'b1, t0);
    #1 d_address = 6'h12;
    wait_bw(1'b1, t1);
    #1 d_address = 6'h13;
    wait_bw(1'b1, t2);
    #1 d_read = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int td, ti, td0, td1, td2, n;
    repeat (2) @(negedge clock);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_d_readdata", d_readdata, 32'h0);
    #1 reset = 1;

    // 1: lone D read
    d_req(0, 6'h0A, '0, td);
    chk("t1_d_readdata", d_readdata, 32'hDEADBEEF);

    // 2: simultaneous reads, last grant was D
    fork
      d_req(0, 6'h07, '0, td);
      i_req(0, 6'h05, '0, ti);
    join
    chk("t2_d_readdata", d_readdata, 32'hA5A50007);
    chk("t2_i_readdata", i_readdata, 32'hA5A50005);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_i_first", 32'(ti < td), 32'h1);
`else
    chk("t2_d_first", 32'(td < ti), 32'h1);
`endif

    // 3: D write then I read of same word
    d_req(1, 6'h03, 32'h12345678, td);
    chk("t3_d_readdata_kept", d_readdata, 32'hA5A50007);
    i_req(0, 6'h03, '0, ti);
    chk("t3_i_readdata", i_readdata, 32'h12345678);

    // 4: reset during WAIT, then re-served
    @(negedge clock);
    #1 d_read = 1; d_address = 6'h0A;
    repeat (4) @(negedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("t4_mem_read", 32'(mem_read), 32'h0);
    chk("t4_i_busywait", 32'(i_busywait), 32'h0);
    chk("t4_d_busywait", 32'(d_busywait), 32'h0);
    chk("t4_d_readdata", d_readdata, 32'h0);
    #1 reset = 1;
    wait_bw(1'b1, td);
    chk("t4_d_reread", d_readdata, 32'hDEADBEEF);
    #1 d_read = 0;

    // 5: read and write together is no request
    @(negedge clock);
    #1 d_read = 1; d_write = 1; d_address = 6'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t5_d_busywait", 32'(d_busywait), 32'h0);
      chk("t5_mem_op", 32'(mem_read | mem_write), 32'h0);
    end
    #1 d_read = 0; d_write = 0;

    // I drops its request mid-transaction; op still completes
    @(negedge clock);
    #1 i_read = 1; i_address = 6'h0A;
    repeat (3) @(negedge clock);
    #1 i_read = 0;
    n = 0;
    repeat (12) @(negedge clock);
    chk("drop_i_readdata", i_readdata, 32'hDEADBEEF);

    // 6: back-to-back D reads with I waiting
    fork
      d_burst(td0, td1, td2);
      i_req(0, 6'h20, '0, ti);
    join
    chk("t6_d_last", d_readdata, 32'hA5A50013);
    chk("t6_i", i_readdata, 32'hA5A50020);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t6_i_between", 32'(ti > td0 && ti < td1), 32'h1);
`else
    chk("t6_i_after", 32'(ti > td2), 32'h1);
`endif

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
